o_feature_store: RTL

O_FEATURE_STORE -- requirements
Module: o_feature_store

---
 rtl/o_feature_store.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/o_feature_store.sv
// Output-feature store engine: streams store_len words from the on-chip output
// bank to external memory through a 2-entry skid FIFO with ready/valid backpressure.
module o_feature_store #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned EXT_AW = 16,
    parameter int unsigned LOC_AW = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              store_enable,
    input  logic [7:0]        store_type,
    input  logic [7:0]        src_addr,
    input  logic [EXT_AW-1:0] dst_addr,
    input  logic [7:0]        mem_sel,
    input  logic [7:0]        store_len,
    output logic [LOC_AW-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              o_mem_select,
    output logic [EXT_AW-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_data,
    output logic              ext_wr_en,
    input  logic              ext_ready,
    output logic              busy,
    output logic              store_done
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    len_q, rd_cnt_q, wr_cnt_q;
    logic [7:0]          type_q;
    logic [LOC_AW-1:0]   rd_ptr_q, rd_hold_q;
    logic                rd_vld_q;
    logic                skid_vld_q;
    logic [DATA_W-1:0]   skid_data_q;
    logic                start_c, pop_c, head_free_c;
    logic [1:0]          occ_c;
    logic [CNT_W-1:0]    beat_next_c;
    logic                unused_ok;

    assign start_c     = store_enable && (state_q != RUN);
    assign pop_c       = ext_wr_en && ext_ready;
    assign head_free_c = !ext_wr_en || pop_c;
    assign beat_next_c = wr_cnt_q + CNT_W'(pop_c);
    // Words buffered plus the read returning now, less the word leaving now.
    assign occ_c       = 2'(ext_wr_en) + 2'(skid_vld_q) + 2'(rd_vld_q) - 2'(pop_c);
    assign rd_addr     = rd_en ? rd_ptr_q : rd_hold_q;
    assign unused_ok   = ^{type_q, mem_sel[7:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and read-issue strobe; reads need ext_ready to keep the pipe full.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_c) state_d = RUN;
            end
            RUN: begin
                rd_en = (rd_cnt_q != len_q) && (occ_c < 2'd2);
                if (beat_next_c == len_q) state_d = DONE;
            end
            DONE: begin
                state_d = start_c ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Job capture, address/count bookkeeping and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy         <= 1'b0;
            store_done   <= 1'b0;
            o_mem_select <= 1'b0;
            len_q        <= '0;
            type_q       <= '0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            rd_ptr_q     <= '0;
            rd_hold_q    <= '0;
            ext_addr     <= '0;
            rd_vld_q     <= 1'b0;
        end else begin
            busy       <= (state_d == RUN);
            store_done <= (state_d == DONE);
            rd_vld_q   <= rd_en;
            if (start_c) begin
                o_mem_select <= mem_sel[0];
                len_q        <= store_len;
                type_q       <= store_type;
                rd_cnt_q     <= '0;
                wr_cnt_q     <= '0;
                rd_ptr_q     <= LOC_AW'(src_addr);
                ext_addr     <= dst_addr;
            end else begin
                if (rd_en) begin
                    rd_cnt_q  <= rd_cnt_q + CNT_W'(1);
                    rd_ptr_q  <= rd_ptr_q + LOC_AW'(1);
                    rd_hold_q <= rd_ptr_q;
                end
                if (pop_c) begin
                    wr_cnt_q <= beat_next_c;
                    ext_addr <= ext_addr + EXT_AW'(1);
                end
            end
        end
    end

    // Two-entry FIFO: head drives ext_data/ext_wr_en directly, skid absorbs one stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_wr_en   <= 1'b0;
            ext_data    <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
        end else if (head_free_c) begin
            if (skid_vld_q) begin
                ext_data  <= skid_data_q;
                ext_wr_en <= 1'b1;
                if (rd_vld_q) begin
                    skid_data_q <= rd_data;
                end else begin
                    skid_vld_q <= 1'b0;
                end
            end else if (rd_vld_q) begin
                ext_data  <= rd_data;
                ext_wr_en <= 1'b1;
            end else begin
                ext_wr_en <= 1'b0;
            end
        end else if (rd_vld_q) begin
            skid_data_q <= rd_data;
            skid_vld_q  <= 1'b1;
        end
    end

endmodule
